fillcap_bank_sequencer: RTL and testbench
=========================================

# fillcap_bank_sequencer

Sequencer for switched fillcap/decap banks in the 9-track 5 V domain. It moves a thermometer-coded bank-enable vector toward a requested level one bank at a time, with a programmable dwell between steps, to limit inrush and supply droop. It sits between the power-management register block and the gated fillcap segment switches, and returns a request/acknowledge handshake to the requester.

## Interface
- NBANK, 8: number of gated fillcap banks, 1..32
- DWELL_W, 4: width of the dwell-count input
- LVL_W, $clog2(NBANK+1): width of the level/target fields (derived, not overridable)

- CLK  in  1  rising-edge clock
- RST  in  1  reset; synchronous, active-high
- REQ  in  1  level request, sampled every rising edge
- TARGET  in  LVL_W  requested number of enabled banks, sampled with REQ
- DWELL  in  DWELL_W  extra wait cycles after each bank change, sampled with REQ
- EN  out  NBANK  bank enables, thermometer code, EN[0] enabled first
- LEVEL  out  LVL_W  popcount of EN (registered)
- BUSY  out  1  sequence in progress
- ACK  out  1  one-cycle pulse when LEVEL reaches the captured target

## Operation
- Reset values: EN=0, LEVEL=0, BUSY=0, ACK=0; state IDLE; captured target and dwell = 0.
- States: IDLE, STEP, WAIT.
- IDLE: REQ=1 captures min(TARGET, NBANK) and DWELL, sets BUSY, and moves to STEP. REQ=0 holds.
- STEP, LEVEL < target: set EN[LEVEL] and increment LEVEL.
- STEP, LEVEL > target: clear EN[LEVEL-1] and decrement LEVEL.
- STEP, after a change: load the dwell counter with DWELL and go to WAIT. If DWELL=0, stay in STEP.
- STEP, LEVEL == target: pulse ACK, clear BUSY, go to IDLE.
- WAIT: decrement the counter. On the cycle the counter reads 1, go to STEP.
- EN changes by exactly one bit per change and always stays thermometer-coded.
- REQ while BUSY: ignored, unless the retarget macro is defined (see Configuration).
- A REQ in the same cycle as the ACK pulse is accepted normally, because that cycle is IDLE.
- RST=1 at any time, including mid-ramp, drops all banks at once (EN=0 on the next edge). This is the only case where more than one bank changes in one cycle.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- REQ accepted at edge t gives BUSY=1 from t+1.
- For a ramp of k banks (k = |target - LEVEL|), the i-th bank change (i=0..k-1) is visible at t+2+i·(DWELL+1).
- ACK is high for the single cycle t+2+k·(DWELL+1), with BUSY=0 in that same cycle.
- k=0 gives ACK at t+2 with no change to EN.
- The dwell counter is DWELL_W bits wide. The maximum dwell is 2^DWELL_W−1 cycles and the counter does not wrap.

## Configuration
- FILLCAP_SEQ_RETARGET_EN, defined: REQ while BUSY recaptures TARGET (clamped) and DWELL at that edge.
  - A WAIT already in progress completes with its old count.
  - The next STEP uses the new target and may reverse direction.
  - A request in a STEP cycle does not affect that cycle's decision.
  - The new DWELL applies from the next counter load.
- FILLCAP_SEQ_RETARGET_EN, undefined: REQ while BUSY is ignored, and the captured target and dwell are fixed until ACK.

## Structure
- Shared package fillcap_seq_pkg holds:
  - the state enum (IDLE, STEP, WAIT);
  - a target-clamp function;
  - default constants for NBANK and DWELL_W.
- One sub-module, fillcap_seq_dwell_cnt: a loadable down-counter with a "last" flag and synchronous reset.
- The top level holds the FSM, the EN/LEVEL registers and the captured target/dwell.

## Test plan
- Ramp up: NBANK=8, DWELL=2, REQ with TARGET=3 at t.
  - EN goes 0x01 at t+2, 0x03 at t+5, 0x07 at t+8.
  - ACK at t+11. BUSY high t+1..t+10.
- Ramp down, zero dwell: from LEVEL=3, DWELL=0, TARGET=0.
  - EN 0x03, 0x01, 0x00 on consecutive cycles starting t+2.
  - ACK at t+5.
- Clamp and no-op:
  - From LEVEL=8, TARGET=12 gives ACK at t+2 with EN=0xFF unchanged.
  - TARGET equal to LEVEL gives ACK at t+2 with EN unchanged.
- Reset mid-ramp: RST asserted during the WAIT after the 2nd bank of a 0→6 ramp.
  - Next edge: EN=0, LEVEL=0, BUSY=0, ACK=0.
  - A later REQ with TARGET=1 completes normally.
- Busy request:
  - Without the macro: REQ TARGET=1 during a 0→5 ramp is ignored, and the ramp ends at 5.
  - With FILLCAP_SEQ_RETARGET_EN: the ramp reverses after the current dwell and ends at 1, with exactly one ACK.
- Thermometer property: random REQ/TARGET/DWELL stream with the macro defined. Check every cycle that EN is thermometer-coded, LEVEL equals popcount(EN), and at most one EN bit changes per cycle unless RST is asserted.

Source files
------------

// File: rtl/fillcap_seq_pkg.sv
// Shared types and helpers for the fillcap bank sequencer.
package fillcap_seq_pkg;

    localparam int unsigned NBANK_DEFAULT   = 8;
    localparam int unsigned DWELL_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StWait
    } seq_state_e;

    function automatic int unsigned clamp_target(input int unsigned target,
                                                 input int unsigned nbank);
        return (target > nbank) ? nbank : target;
    endfunction

endpackage

// File: rtl/fillcap_seq_dwell_cnt.sv
// Loadable saturating down-counter; last flags the final dwell cycle (count == 1).
module fillcap_seq_dwell_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/fillcap_bank_sequencer.sv
// Steps a thermometer-coded bank-enable vector toward a requested level with a dwell per step.
// Optional: define FILLCAP_SEQ_RETARGET_EN to let a request during a sequence retarget it.
module fillcap_bank_sequencer
    import fillcap_seq_pkg::*;
#(
    parameter  int unsigned NBANK   = NBANK_DEFAULT,
    parameter  int unsigned DWELL_W = DWELL_W_DEFAULT,
    localparam int unsigned LVL_W   = $clog2(NBANK + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ,
    input  logic [LVL_W-1:0]   TARGET,
    input  logic [DWELL_W-1:0] DWELL,
    output logic [NBANK-1:0]   EN,
    output logic [LVL_W-1:0]   LEVEL,
    output logic               BUSY,
    output logic               ACK
);

    seq_state_e         state_q, state_d;
    logic [NBANK-1:0]   en_q, en_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   tgt_q, tgt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic [LVL_W-1:0]   tgt_in;
    logic               changed;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_last;

    assign tgt_in = LVL_W'(clamp_target(32'(TARGET), NBANK));

    fillcap_seq_dwell_cnt #(
        .W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (dwell_q),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        level_d  = level_q;
        tgt_d    = tgt_q;
        dwell_d  = dwell_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        changed  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (REQ) begin
                    tgt_d   = tgt_in;
                    dwell_d = DWELL;
                    busy_d  = 1'b1;
                    state_d = StStep;
                end
            end
            StStep: begin
                // Shifting keeps EN thermometer-coded: one bit in or out at the top.
                if (level_q < tgt_q) begin
                    en_d    = (en_q << 1) | NBANK'(1);
                    level_d = level_q + LVL_W'(1);
                    changed = 1'b1;
                end else if (level_q > tgt_q) begin
                    en_d    = en_q >> 1;
                    level_d = level_q - LVL_W'(1);
                    changed = 1'b1;
                end else begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
                if (changed && (dwell_q != '0)) begin
                    cnt_load = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = StStep;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef FILLCAP_SEQ_RETARGET_EN
        // Captured values are registered, so this cycle's STEP decision still uses the old ones.
        if (busy_q && REQ) begin
            tgt_d   = tgt_in;
            dwell_d = DWELL;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            en_q    <= '0;
            level_q <= '0;
            tgt_q   <= '0;
            dwell_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            level_q <= level_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign EN    = en_q;
    assign LEVEL = level_q;
    assign BUSY  = busy_q;
    assign ACK   = ack_q;

endmodule

// File: tb/tb_fillcap_bank_sequencer.sv
// Scoreboard bench for fillcap_bank_sequencer (NBANK=8, DWELL_W=4).
module tb_fillcap_bank_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ = 1'b0;
    logic [3:0] TARGET = '0;
    logic [3:0] DWELL = '0;
    logic [7:0] EN;
    logic [3:0] LEVEL;
    logic       BUSY;
    logic       ACK;

    fillcap_bank_sequencer #(
        .NBANK   (8),
        .DWELL_W (4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .TARGET (TARGET),
        .DWELL  (DWELL),
        .EN     (EN),
        .LEVEL  (LEVEL),
        .BUSY   (BUSY),
        .ACK    (ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [7:0] en;
        int         lvl;
    } exp_t;

    exp_t chg_q[$];
    exp_t ack_q[$];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   mlevel = 0;
    bit   sb_en = 1'b1;
    logic [7:0] en_prev = '0;
    logic       rst_prev = 1'b1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] thermo(input int n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    // Monitor: property checks every cycle, scoreboard pops on EN changes and ACK pulses.
    always @(negedge CLK) begin
        logic [8:0] e;
        exp_t       it;
        e = {1'b0, EN};
        chk("thermometer", 32'(((e + 9'd1) & e) == 9'd0), 32'd1);
        chk("level_popcount", 32'(LEVEL), 32'($countones(EN)));
        if (!rst_prev) begin
            chk("single_step", 32'($countones(EN ^ en_prev) <= 1), 32'd1);
        end
        if (sb_en && !rst_prev && (EN != en_prev)) begin
            if (chg_q.size() == 0) begin
                chk("unexpected_en_change", 32'(EN), 32'(en_prev));
            end else begin
                it = chg_q.pop_front();
                chk("en_change_cycle", 32'(cyc), 32'(it.cyc));
                chk("en_change_value", 32'(EN), 32'(it.en));
            end
        end
        if (sb_en && ACK) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", 32'(ACK), 32'd0);
            end else begin
                it = ack_q.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(it.cyc));
                chk("ack_en", 32'(EN), 32'(it.en));
                chk("ack_level", 32'(LEVEL), 32'(it.lvl));
                chk("ack_busy_low", 32'(BUSY), 32'd0);
            end
        end
        en_prev  = EN;
        rst_prev = RST;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    // Issue a request and queue the expected EN steps plus the hand-computed ACK.
    task automatic do_req(input int tgt, input int dw, input int ack_off,
                          input logic [7:0] en_fin);
        int c0, tc, k, dir;
        exp_t it;
        c0  = cyc;
        tc  = (tgt > 8) ? 8 : tgt;
        dir = (tc >= mlevel) ? 1 : -1;
        k   = (tc >= mlevel) ? tc - mlevel : mlevel - tc;
        for (int i = 0; i < k; i++) begin
            it.cyc = c0 + 2 + i * (dw + 1);
            it.lvl = mlevel + dir * (i + 1);
            it.en  = thermo(it.lvl);
            chg_q.push_back(it);
        end
        it.cyc = c0 + ack_off;
        it.en  = en_fin;
        it.lvl = $countones(en_fin);
        ack_q.push_back(it);
        mlevel = tc;
        REQ    = 1'b1;
        TARGET = 4'(tgt);
        DWELL  = 4'(dw);
        step();
        REQ = 1'b0;
        @(negedge CLK);
        chk("busy_after_req", 32'(BUSY), 32'd1);
        wait_cyc(c0 + ack_off);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
        mlevel = 0;
    endtask

    initial begin
        int   c0;
        exp_t it;
        repeat (3) step();
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_en", 32'(EN), 32'd0);
        chk("reset_level", 32'(LEVEL), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_ack", 32'(ACK), 32'd0);
        step();

        do_req(3, 2, 11, 8'h07);   // ramp up with dwell
        do_req(0, 0, 5, 8'h00);    // ramp down, zero dwell
        do_req(8, 1, 18, 8'hFF);   // full ramp
        do_req(12, 3, 2, 8'hFF);   // clamped, no-op
        do_req(8, 0, 2, 8'hFF);    // equal target, no-op
        do_req(6, 0, 4, 8'h3F);
        do_req(7, 1, 4, 8'h7F);

        // Reset mid-ramp during the WAIT after the 2nd bank of a 0->6 ramp.
        do_reset();
        c0 = cyc;
        it = '{cyc: c0 + 2, en: 8'h01, lvl: 1};
        chg_q.push_back(it);
        it = '{cyc: c0 + 6, en: 8'h03, lvl: 2};
        chg_q.push_back(it);
        REQ = 1'b1; TARGET = 4'd6; DWELL = 4'd3;
        step();
        REQ = 1'b0;
        wait_cyc(c0 + 7);
        RST = 1'b1;
        step();
        RST = 1'b0;
        mlevel = 0;
        @(negedge CLK);
        chk("midramp_rst_en", 32'(EN), 32'd0);
        chk("midramp_rst_level", 32'(LEVEL), 32'd0);
        chk("midramp_rst_busy", 32'(BUSY), 32'd0);
        chk("midramp_rst_ack", 32'(ACK), 32'd0);
        step();
        do_req(1, 0, 3, 8'h01);
        do_req(0, 0, 3, 8'h00);

        // Request while busy during a 0->5 ramp.
        c0 = cyc;
`ifdef FILLCAP_SEQ_RETARGET_EN
        it = '{cyc: c0 + 2, en: 8'h01, lvl: 1}; chg_q.push_back(it);
        it = '{cyc: c0 + 5, en: 8'h03, lvl: 2}; chg_q.push_back(it);
        it = '{cyc: c0 + 8, en: 8'h01, lvl: 1}; chg_q.push_back(it);
        it = '{cyc: c0 + 9, en: 8'h01, lvl: 1}; ack_q.push_back(it);
        mlevel = 1;
`else
        it = '{cyc: c0 + 2, en: 8'h01, lvl: 1}; chg_q.push_back(it);
        it = '{cyc: c0 + 5, en: 8'h03, lvl: 2}; chg_q.push_back(it);
        it = '{cyc: c0 + 8, en: 8'h07, lvl: 3}; chg_q.push_back(it);
        it = '{cyc: c0 + 11, en: 8'h0F, lvl: 4}; chg_q.push_back(it);
        it = '{cyc: c0 + 14, en: 8'h1F, lvl: 5}; chg_q.push_back(it);
        it = '{cyc: c0 + 17, en: 8'h1F, lvl: 5}; ack_q.push_back(it);
        mlevel = 5;
`endif
        REQ = 1'b1; TARGET = 4'd5; DWELL = 4'd2;
        step();
        REQ = 1'b0;
        wait_cyc(c0 + 6);
        REQ = 1'b1; TARGET = 4'd1; DWELL = 4'd0;
        step();
        REQ = 1'b0;
        wait_cyc(c0 + 20);

        chk("chg_queue_drained", 32'(chg_q.size()), 32'd0);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);

        // Random stream: only the per-cycle properties are checked from here on.
        sb_en = 1'b0;
        for (int i = 0; i < 400; i++) begin
            REQ    = ($urandom_range(0, 3) == 0);
            TARGET = 4'($urandom_range(0, 15));
            DWELL  = 4'($urandom_range(0, 3));
            RST    = ($urandom_range(0, 60) == 0);
            step();
        end
        REQ = 1'b0;
        do_reset();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
